// File: rtl/sound_pkg.sv
// Shared types and the constant sound table for the sound sequencer.
// Priority follows sound id order: lower id wins.
package sound_pkg;

   typedef enum logic [2:0] {
      SND_HOLE   = 3'd0,
      SND_BALL   = 3'd1,
      SND_BORDER = 3'd2,
      SND_ENTER  = 3'd3,
      SND_KEYX   = 3'd4,
      SND_KEYY   = 3'd5,
      SND_NONE   = 3'd7
   } soundIdT;

   typedef struct packed {
      logic [3:0] note1;
      logic [7:0] dur1;
      logic [3:0] note2;
      logic [7:0] dur2;
   } soundEntryT;

   localparam int NUM_SOUNDS = 6;

   // Padded to eight entries so any 3-bit id indexes safely; ids 6 and 7 are silent.
   localparam soundEntryT SOUND_TABLE [8] = '{
      '{note1: 4'd10, dur1: 8'd150, note2: 4'd6,  dur2: 8'd150},
      '{note1: 4'd12, dur1: 8'd40,  note2: 4'd0,  dur2: 8'd0},
      '{note1: 4'd4,  dur1: 8'd30,  note2: 4'd0,  dur2: 8'd0},
      '{note1: 4'd8,  dur1: 8'd80,  note2: 4'd11, dur2: 8'd80},
      '{note1: 4'd2,  dur1: 8'd20,  note2: 4'd0,  dur2: 8'd0},
      '{note1: 4'd3,  dur1: 8'd20,  note2: 4'd0,  dur2: 8'd0},
      '{note1: 4'd0,  dur1: 8'd0,   note2: 4'd0,  dur2: 8'd0},
      '{note1: 4'd0,  dur1: 8'd0,   note2: 4'd0,  dur2: 8'd0}
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_NOTE1,
      ST_NOTE2,
      ST_GAP
   } seqStateT;

   function automatic soundEntryT soundLookup(input soundIdT id);
      logic [2:0] idx;
      idx = id;
      return SOUND_TABLE[idx];
   endfunction

   function automatic soundIdT highestPending(input logic [NUM_SOUNDS-1:0] pend);
      soundIdT winner;
      winner = SND_NONE;
      for (int i = NUM_SOUNDS - 1; i >= 0; i--) begin
         if (pend[i]) winner = soundIdT'(i[2:0]);
      end
      return winner;
   endfunction

endpackage

// File: rtl/sound_sequencer_if.sv
// Request lines from the sound request mux and tone controls toward the tone generator.
interface sound_sequencer_if;

   logic       holeColAudioRequest;
   logic       ballToBallColAudioRequest;
   logic       borderColAudioRequest;
   logic       keyEnterAudioRequest;
   logic       keyXAudioRequest;
   logic       keyYAudioRequest;
   logic       enableSound;
   logic [3:0] freqIdx;
   logic [2:0] activeSound;
   logic       busy;

   modport slave (
      input  holeColAudioRequest, ballToBallColAudioRequest, borderColAudioRequest,
      input  keyEnterAudioRequest, keyXAudioRequest, keyYAudioRequest,
      output enableSound, freqIdx, activeSound, busy
   );

   modport master (
      output holeColAudioRequest, ballToBallColAudioRequest, borderColAudioRequest,
      output keyEnterAudioRequest, keyXAudioRequest, keyYAudioRequest,
      input  enableSound, freqIdx, activeSound, busy
   );

endinterface

// File: rtl/sound_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV clocks, restartable by clear_i.
module sound_tick_gen #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic resetN,
   input  logic clear_i,
   output logic tick_o
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_o = (cnt_q == CNT_LAST);
      cnt_d  = (clear_i || tick_o) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetN) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/sound_sequencer.sv
// Edge-detects six audio requests, queues them as pending bits and plays them by priority.
// Optional SOUND_PREEMPT_EN lets a higher-priority request abort the sound in progress.
module sound_sequencer
   import sound_pkg::*;
#(
   parameter int TICK_DIV = 50000,
   parameter int GAP_MS   = 20
) (
   input logic            clk,
   input logic            resetN,
   sound_sequencer_if.slave bus
);

   logic [NUM_SOUNDS-1:0] reqVec, reqRise, grantMask;
   logic [NUM_SOUNDS-1:0] reqPrev_q, pending_q, pending_d;
   seqStateT              state_q, state_d;
   soundIdT               activeSound_q, activeSound_d, grantId;
   logic [3:0]            freqIdx_q, freqIdx_d;
   logic [15:0]           msCnt_q, msCnt_d, targetMs;
   soundEntryT            curEntry, grantEntry;
   logic                  tick, clearCnt, grant, msDone;

   sound_tick_gen #(.TICK_DIV(TICK_DIV)) tickGen (
      .clk     (clk),
      .resetN  (resetN),
      .clear_i (clearCnt),
      .tick_o  (tick)
   );

   always_comb begin
      reqVec     = {bus.keyYAudioRequest, bus.keyXAudioRequest, bus.keyEnterAudioRequest,
                    bus.borderColAudioRequest, bus.ballToBallColAudioRequest,
                    bus.holeColAudioRequest};
      reqRise    = reqVec & ~reqPrev_q;
      grantId    = highestPending(pending_q);
      curEntry   = soundLookup(activeSound_q);
      grantEntry = soundLookup(grantId);
      case (state_q)
         ST_NOTE1: targetMs = {8'd0, curEntry.dur1};
         ST_NOTE2: targetMs = {8'd0, curEntry.dur2};
         ST_GAP:   targetMs = 16'(GAP_MS);
         default:  targetMs = 16'd1;
      endcase
      msDone = tick && (msCnt_q == targetMs - 16'd1);
   end

   // Every state entry restarts the prescaler so each note lasts exactly dur ms.
   always_comb begin
      state_d       = state_q;
      activeSound_d = activeSound_q;
      freqIdx_d     = freqIdx_q;
      grant         = 1'b0;
      clearCnt      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|pending_q) grant = 1'b1;
         end
         ST_NOTE1: begin
            if (msDone) begin
               clearCnt = 1'b1;
               if (curEntry.dur2 != 8'd0) begin
                  state_d   = ST_NOTE2;
                  freqIdx_d = curEntry.note2;
               end else begin
                  state_d = ST_GAP;
               end
            end
         end
         ST_NOTE2: begin
            if (msDone) begin
               clearCnt = 1'b1;
               state_d  = ST_GAP;
            end
         end
         ST_GAP: begin
            if (msDone) begin
               clearCnt      = 1'b1;
               state_d       = ST_IDLE;
               activeSound_d = SND_NONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef SOUND_PREEMPT_EN
      if (state_q != ST_IDLE && grantId < activeSound_q) grant = 1'b1;
`endif
      if (grant) begin
         state_d       = ST_NOTE1;
         clearCnt      = 1'b1;
         activeSound_d = grantId;
         freqIdx_d     = grantEntry.note1;
      end
      grantMask = grant ? (NUM_SOUNDS'(1) << grantId) : '0;
      pending_d = (pending_q & ~grantMask) | reqRise;
      msCnt_d   = clearCnt ? 16'd0 : (tick ? msCnt_q + 16'd1 : msCnt_q);
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q       <= ST_IDLE;
         activeSound_q <= SND_NONE;
         freqIdx_q     <= 4'd0;
         reqPrev_q     <= '0;
         pending_q     <= '0;
         msCnt_q       <= 16'd0;
      end else begin
         state_q       <= state_d;
         activeSound_q <= activeSound_d;
         freqIdx_q     <= freqIdx_d;
         reqPrev_q     <= reqVec;
         pending_q     <= pending_d;
         msCnt_q       <= msCnt_d;
      end
   end

   assign bus.enableSound = (state_q == ST_NOTE1) || (state_q == ST_NOTE2);
   assign bus.freqIdx     = freqIdx_q;
   assign bus.activeSound = activeSound_q;
   assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench for sound_sequencer: a timeline model predicts note/gap segments,
// a monitor measures the segments the DUT actually plays and compares them.
module tb_sound_sequencer;

   localparam int TD  = 10;
   localparam int GAP = 2;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic [5:0] drive = '0;

   sound_sequencer_if bus();

   assign bus.holeColAudioRequest       = drive[0];
   assign bus.ballToBallColAudioRequest = drive[1];
   assign bus.borderColAudioRequest     = drive[2];
   assign bus.keyEnterAudioRequest      = drive[3];
   assign bus.keyXAudioRequest          = drive[4];
   assign bus.keyYAudioRequest          = drive[5];

   sound_sequencer #(.TICK_DIV(TD), .GAP_MS(GAP)) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;
      int id;
      int freq;
      int start;
      int len;
   } segT;

   segT  expQ[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   bit   sbEnable = 1'b1;

   int tNote1[6] = '{10, 12, 4, 8, 2, 3};
   int tDur1[6]  = '{150, 40, 30, 80, 20, 20};
   int tNote2[6] = '{6, 0, 0, 11, 0, 0};
   int tDur2[6]  = '{150, 0, 0, 80, 0, 0};

   logic [5:0] mPrev = '0;
   logic [5:0] mPending = '0;
   int         mFreeAt = 0;

   // A granted sound is laid out on the timeline as note1, optional note2, then the gap.
   task automatic pushSound(input int id, input int k);
      int d1, d2, t, lastFreq;
      d1 = tDur1[id] * TD;
      d2 = tDur2[id] * TD;
      expQ.push_back(segT'{1, id, tNote1[id], k, d1});
      t = k + d1;
      lastFreq = tNote1[id];
      if (d2 != 0) begin
         expQ.push_back(segT'{1, id, tNote2[id], t, d2});
         t += d2;
         lastFreq = tNote2[id];
      end
      expQ.push_back(segT'{2, id, lastFreq, t, GAP * TD});
      mFreeAt = t + GAP * TD + 1;
   endtask

   always @(posedge clk) begin : model
      logic [5:0] rise;
      int g;
      cyc = cyc + 1;
      if (!resetN) begin
         mPrev = '0;
         mPending = '0;
         mFreeAt = 0;
         expQ.delete();
      end else begin
         rise = drive & ~mPrev;
         if (cyc >= mFreeAt && mPending != 0) begin
            g = 0;
            for (int i = 5; i >= 0; i--) if (mPending[i]) g = i;
            pushSound(g, cyc);
            mPending[g] = 1'b0;
         end
         mPending = mPending | rise;
         mPrev = drive;
      end
   end

   task automatic checkSegment(input int kind, input int id, input int freq,
                               input int start, input int len);
      segT e;
      tests++;
      if (expQ.size() == 0) begin
         fails++;
         $display("[TB] FAIL segment unexpected: got kind=%0d id=%0d freq=%0d start=%0d len=%0d, none expected",
                  kind, id, freq, start, len);
      end else begin
         e = expQ.pop_front();
         if (e.kind != kind || e.id != id || e.freq != freq || e.start != start || e.len != len) begin
            fails++;
            $display("[TB] FAIL segment: got kind=%0d id=%0d freq=%0d start=%0d len=%0d, expected kind=%0d id=%0d freq=%0d start=%0d len=%0d",
                     kind, id, freq, start, len, e.kind, e.id, e.freq, e.start, e.len);
         end
      end
   endtask

   int curKind = 0, curId = 0, curFreq = 0, curStart = 0, curLen = 0;

   // Segments are emitted when the observed (kind, id, freq) changes.
   always @(negedge clk) begin : monitor
      int kind;
      if (!resetN || !sbEnable) begin
         curKind = 0;
      end else begin
         kind = !bus.busy ? 0 : (bus.enableSound ? 1 : 2);
         if (kind != curKind ||
             (kind != 0 && (int'(bus.freqIdx) != curFreq || int'(bus.activeSound) != curId))) begin
            if (curKind != 0) checkSegment(curKind, curId, curFreq, curStart, curLen);
            curKind  = kind;
            curId    = int'(bus.activeSound);
            curFreq  = int'(bus.freqIdx);
            curStart = cyc;
            curLen   = 1;
         end else begin
            curLen++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [5:0] pattern, input int hold);
      @(negedge clk);
      drive = drive | pattern;
      repeat (hold) @(negedge clk);
      drive = drive & ~pattern;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while (!(bus.busy == 1'b0 && mPending == 0 && cyc >= mFreeAt) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         tests++;
         fails++;
         $display("[TB] FAIL idle wait: still busy after %0d cycles, required idle", budget);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " enableSound"}, int'(bus.enableSound), 0);
      checkOutput({tag, " freqIdx"}, int'(bus.freqIdx), 0);
      checkOutput({tag, " activeSound"}, int'(bus.activeSound), 7);
      checkOutput({tag, " busy"}, int'(bus.busy), 0);
   endtask

   initial begin
      int n, bad;
      resetN = 1'b0;
      drive  = '0;
      tick(3);
      checkResetState("reset");
      resetN = 1'b1;
      tick(5);

      applyStimulus(6'b010000, 1);
      waitIdle(2000);

      applyStimulus(6'b000001, 1);
      waitIdle(5000);

      applyStimulus(6'b101100, 1);
      waitIdle(6000);

      applyStimulus(6'b001000, 5000);
      waitIdle(3000);

`ifdef SOUND_PREEMPT_EN
      sbEnable = 1'b0;
      applyStimulus(6'b001000, 1);
      n = 0;
      while (!(bus.enableSound && bus.freqIdx == 4'd8) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("enter start wait", (n < 100) ? 1 : 0, 1);
      tick(50);
      applyStimulus(6'b000010, 1);
      tick(1);
      checkOutput("preempt freqIdx", int'(bus.freqIdx), 12);
      checkOutput("preempt activeSound", int'(bus.activeSound), 1);
      checkOutput("preempt enableSound", int'(bus.enableSound), 1);
      n = 0;
      bad = 0;
      while (bus.busy && n < 2000) begin
         if (bus.enableSound && (bus.freqIdx == 4'd8 || bus.freqIdx == 4'd11)) bad++;
         @(negedge clk);
         n++;
      end
      checkOutput("enter resumed cycles", bad, 0);
      resetN = 1'b0;
      tick(2);
      sbEnable = 1'b1;
      resetN = 1'b1;
      tick(2);
`else
      applyStimulus(6'b001000, 1);
      n = 0;
      while (!(bus.enableSound && bus.freqIdx == 4'd8) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("enter start wait", (n < 100) ? 1 : 0, 1);
      tick(50);
      applyStimulus(6'b000010, 1);
      waitIdle(5000);
`endif

      applyStimulus(6'b000001, 1);
      tick(100);
      applyStimulus(6'b010000, 1);
      tick(20);
      resetN = 1'b0;
      tick(1);
      checkResetState("mid-sound reset");
      tick(3);
      resetN = 1'b1;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.busy) n++;
      end
      checkOutput("busy cycles after reset release", n, 0);

      for (int it = 0; it < 14; it++) begin
`ifdef SOUND_PREEMPT_EN
         waitIdle(8000);
`endif
         applyStimulus(6'($urandom_range(1, 63)), $urandom_range(1, 3));
         tick($urandom_range(0, 2500));
      end
      waitIdle(20000);
      tick(5);

      checkOutput("scoreboard leftover", expQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
